bcd_value_entry: RTL and testbench

- Digit-entry front end that produces the binary count the up/down display counter consumes.
- The operator edits four decimal digits with debounced push-buttons, then commits them.
- On commit, the block converts the BCD digits to binary sequentially, clamps the result, and presents it with a one-cycle valid strobe as a preload value.
- Digits and cursor are output so the existing 7-segment decoders can show the entry in progress.

---
 rtl/bcd_value_entry_if.sv | 18 +
 rtl/bcd_value_entry.sv | 77 +++++++
 tb/tb_bcd_value_entry.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bcd_value_entry_if.sv
// bcd_value_entry_if: operator keys/enable in; digits, cursor and committed value out
// master: drives en and the active-low keys, observes the entry state
// slave: the entry block itself
interface bcd_value_entry_if #(parameter int VAL_W = 14);
  logic en, key_sel, key_inc, key_dec, key_ent;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] cursor;
  logic [VAL_W-1:0] value;
  logic value_valid, busy;
  modport master (
    output en, key_sel, key_inc, key_dec, key_ent,
    input digit0, digit1, digit2, digit3, cursor, value, value_valid, busy
  );
  modport slave (
    input en, key_sel, key_inc, key_dec, key_ent,
    output digit0, digit1, digit2, digit3, cursor, value, value_valid, busy
  );
endinterface

// File: rtl/bcd_value_entry.sv
// bcd_value_entry: four-digit BCD entry with push-buttons, committed as a clamped binary preload
// clk/reset: system clock, synchronous active-high reset
// bus: en + active-low keys in; digit0..3, cursor, value, value_valid strobe, busy out
module bcd_value_entry #(
  parameter int MAX_VALUE = 1000,
  parameter int VAL_W = 14
) (
  input logic clk,
  input logic reset,
  bcd_value_entry_if.slave bus
);
  typedef enum logic [1:0] {EDIT, CONV, DONE} state_t;
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VALUE);
  state_t state_q, state_d;
  logic [3:0] hist_q, hist_d, press;
  logic [3:0][3:0] dig_q, dig_d;
  logic [1:0] cursor_q, cursor_d, idx_q, idx_d;
  logic [VAL_W-1:0] acc_q, acc_d, value_q, value_d;
  logic valid_q, valid_d, busy_q, busy_d;
  // key vectors are ordered {ent, sel, inc, dec}, highest priority first
  assign hist_d = {bus.key_ent, bus.key_sel, bus.key_inc, bus.key_dec};
  assign press = hist_q & ~hist_d;
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    cursor_d = cursor_q;
    idx_d = idx_q;
    acc_d = acc_q;
    value_d = value_q;
    valid_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      EDIT: if (bus.en) begin
        if (press[3]) begin
          acc_d = '0;
          idx_d = 2'd3;
          busy_d = 1'b1;
          state_d = CONV;
        end else if (press[2]) cursor_d = cursor_q + 2'd1;
        else if (press[1]) dig_d[cursor_q] = dig_q[cursor_q] == 4'd9 ? 4'd0 : dig_q[cursor_q] + 4'd1;
        else if (press[0]) dig_d[cursor_q] = dig_q[cursor_q] == 4'd0 ? 4'd9 : dig_q[cursor_q] - 4'd1;
      end
      // Horner evaluation from the thousands digit down
      CONV: begin
        acc_d = acc_q * VAL_W'(10) + VAL_W'(dig_q[idx_q]);
        idx_d = idx_q - 2'd1;
        state_d = idx_q == 2'd0 ? DONE : CONV;
      end
      DONE: begin
        value_d = acc_q > MAX_V ? MAX_V : acc_q;
        valid_d = 1'b1;
        busy_d = 1'b0;
        state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end
  always_ff @(posedge clk) begin
    hist_q <= reset ? 4'hf : hist_d;
    state_q <= reset ? EDIT : state_d;
    dig_q <= reset ? '0 : dig_d;
    cursor_q <= reset ? 2'd0 : cursor_d;
    idx_q <= reset ? 2'd0 : idx_d;
    acc_q <= reset ? '0 : acc_d;
    value_q <= reset ? '0 : value_d;
    valid_q <= reset ? 1'b0 : valid_d;
    busy_q <= reset ? 1'b0 : busy_d;
  end
  assign bus.digit0 = dig_q[0];
  assign bus.digit1 = dig_q[1];
  assign bus.digit2 = dig_q[2];
  assign bus.digit3 = dig_q[3];
  assign bus.cursor = cursor_q;
  assign bus.value = value_q;
  assign bus.value_valid = valid_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_bcd_value_entry.sv
// tb_bcd_value_entry: checks two entry blocks (clamp 1000 and 9999) against a digit/arithmetic model
module tb_bcd_value_entry;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  bcd_value_entry_if #(.VAL_W(14)) ifa ();
  bcd_value_entry_if #(.VAL_W(14)) ifb ();
  bcd_value_entry #(.MAX_VALUE(1000), .VAL_W(14)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  bcd_value_entry #(.MAX_VALUE(9999), .VAL_W(14)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  logic [3:0] da [4], db [4];
  assign da = '{ifa.digit0, ifa.digit1, ifa.digit2, ifa.digit3};
  assign db = '{ifb.digit0, ifb.digit1, ifb.digit2, ifb.digit3};
  int n_vec = 0, n_err = 0;
  int dig [4];
  int cur, va, vb;
  bit en_r;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_keys(input logic [3:0] lv);
    {ifa.key_ent, ifa.key_sel, ifa.key_inc, ifa.key_dec} = lv;
    {ifb.key_ent, ifb.key_sel, ifb.key_inc, ifb.key_dec} = lv;
  endtask
  task automatic set_en(input bit e);
    en_r = e;
    ifa.en = e;
    ifb.en = e;
  endtask
  task automatic model_reset();
    foreach (dig[i]) dig[i] = 0;
    cur = 0;
    va = 0;
    vb = 0;
  endtask
  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_dig_a"}, int'(da[i]), dig[i]);
      chk({tag, "_dig_b"}, int'(db[i]), dig[i]);
    end
    chk({tag, "_cursor"}, int'(ifa.cursor), cur);
    chk({tag, "_value_a"}, int'(ifa.value), va);
    chk({tag, "_value_b"}, int'(ifb.value), vb);
    chk({tag, "_busy"}, int'(ifa.busy), 0);
    chk({tag, "_valid"}, int'(ifa.value_valid), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_keys(4'hf);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_state("reset");
  endtask
  // m = {ent, sel, inc, dec}; drop >= 0 lowers en at that conversion step
  task automatic press(input logic [3:0] m, input int hold, input int drop);
    int total;
    bit ent;
    @(negedge clk);
    set_keys(~m);
    @(posedge clk);
    #1;
    ent = 1'b0;
    if (en_r) begin
      if (m[3]) ent = 1'b1;
      else if (m[2]) cur = (cur + 1) % 4;
      else if (m[1]) dig[cur] = (dig[cur] + 1) % 10;
      else if (m[0]) dig[cur] = (dig[cur] + 9) % 10;
    end
    if (ent) begin
      total = 1000 * dig[3] + 100 * dig[2] + 10 * dig[1] + dig[0];
      for (int e = 0; e <= 5; e++) begin
        if (e > 0) begin
          @(posedge clk);
          #1;
        end
        if (e == drop) set_en(1'b0);
        if (e == 5) begin
          va = total > 1000 ? 1000 : total;
          vb = total;
        end
        chk("conv_busy", int'(ifa.busy), int'(e < 5));
        chk("conv_valid_a", int'(ifa.value_valid), int'(e == 5));
        chk("conv_valid_b", int'(ifb.value_valid), int'(e == 5));
        chk("conv_value_a", int'(ifa.value), va);
        chk("conv_value_b", int'(ifb.value), vb);
      end
    end else begin
      chk("press_busy", int'(ifa.busy), 0);
      chk("press_valid", int'(ifa.value_valid), 0);
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    set_keys(4'hf);
    repeat (3) @(posedge clk);
    #1 check_state("after_press");
  endtask
  initial begin
    reset = 1'b1;
    set_en(1'b1);
    set_keys(4'hf);
    model_reset();
    do_reset();
    repeat (7) press(4'b0010, 3, -1);
    press(4'b1000, 3, -1);
    chk("t1_value", int'(ifa.value), 7);
    do_reset();
    repeat (3) press(4'b0100, 3, -1);
    press(4'b0010, 3, -1);
    press(4'b0100, 3, -1);
    repeat (4) press(4'b0010, 3, -1);
    press(4'b0100, 3, -1);
    repeat (3) press(4'b0010, 3, -1);
    press(4'b0100, 3, -1);
    repeat (2) press(4'b0010, 3, -1);
    press(4'b1000, 3, -1);
    chk("t2_clamped", int'(ifa.value), 1000);
    chk("t2_unclamped", int'(ifb.value), 1234);
    do_reset();
    press(4'b0001, 3, -1);
    chk("t3_dec_wrap", int'(ifa.digit0), 9);
    press(4'b0010, 3, -1);
    chk("t3_inc_wrap", int'(ifa.digit0), 0);
    repeat (4) press(4'b0100, 3, -1);
    chk("t3_cursor_wrap", int'(ifa.cursor), 0);
    press(4'b0010, 50, -1);
    chk("t4_held_once", int'(ifa.digit0), 1);
    press(4'b0110, 3, -1);
    chk("t4_prio_cursor", int'(ifa.cursor), 1);
    set_en(1'b0);
    press(4'b0010, 3, -1);
    press(4'b0100, 3, -1);
    press(4'b1000, 3, -1);
    set_en(1'b1);
    press(4'b0010, 3, -1);
    press(4'b1000, 3, 2);
    set_en(1'b1);
    chk("t5_value", int'(ifb.value), 11);
    @(negedge clk);
    set_keys(4'b0111);
    @(posedge clk);
    #1 chk("t6_busy_start", int'(ifa.busy), 1);
    @(posedge clk);
    @(negedge clk);
    set_keys(4'hf);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_state("t6_abort");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("t6_no_strobe", int'(ifa.value_valid), 0);
    end
    for (int it = 0; it < 120; it++) begin
      logic [3:0] m;
      set_en($urandom_range(0, 5) != 0);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
      if (m[3] && $urandom_range(0, 2) != 0) m[3] = 1'b0;
      if (m == 4'd0) m = 4'b0010;
      press(m, $urandom_range(0, 6), -1);
    end
    set_en(1'b1);
    press(4'b1000, 2, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
